// File: rtl/mem_sequencer.sv
// rtl/mem_sequencer.sv - core-to-memory access sequencer with optional address-phase reuse
module mem_sequencer #(
    parameter int ADDR_REUSE = 1
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_reqValid,
    output logic       o_reqReady,
    input  logic [1:0] i_reqType,
    input  logic [7:0] i_reqAddr,
    input  logic [7:0] i_reqWData,
    input  logic       i_invalidate,
    output logic       o_rspValid,
    output logic [7:0] o_rspData,
    output logic [7:0] o_address,
    output logic       o_addressEn,
    output logic [7:0] o_writeData,
    output logic       o_writeEn,
    output logic       o_readDataSelect,
    output logic       o_immediateSelect,
    output logic       o_outEnable,
    input  logic [7:0] i_readData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t     state, nextState;
    logic [1:0] r_type;
    logic [7:0] r_wdata;
    logic [7:0] r_lastAddr;
    logic       r_addrValid;
    logic       accept;
    logic       reuseHit;
    logic [1:0] accType;
    logic [7:0] accData;

    // Next-state, handshake and strobe decode; strobes are combinational so reset drops them at once
    always_comb begin
        nextState   = state;
        o_reqReady  = 1'b0;
        o_addressEn = 1'b0;
        o_outEnable = 1'b0;
        o_writeEn   = 1'b0;
        accept      = 1'b0;
        reuseHit    = (ADDR_REUSE != 0) && r_addrValid && (i_reqAddr == r_lastAddr);
        // Entering ACCESS straight from IDLE means the request is on the inputs, not yet registered
        accType     = (state == IDLE) ? i_reqType : r_type;
        accData     = (state == IDLE) ? i_reqWData : r_wdata;
        case (state)
            IDLE: begin
                o_reqReady = 1'b1;
                if (i_reqValid) begin
                    accept    = 1'b1;
                    nextState = reuseHit ? ACCESS : ADDR;
                end
            end
            ADDR: begin
                o_addressEn = 1'b1;
                nextState   = ACCESS;
            end
            ACCESS: begin
                o_writeEn   = (r_type == 2'b11);
                o_outEnable = (r_type != 2'b11);
                nextState   = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Request capture; o_address doubles as the registered address since it only moves on acceptance
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_type    <= 2'b00;
            r_wdata   <= 8'h00;
            o_address <= 8'h00;
        end else if (accept) begin
            r_type    <= i_reqType;
            r_wdata   <= i_reqWData;
            o_address <= i_reqAddr;
        end
    end

    // Address-reuse tracking; the immediate bit is deliberately not part of the tag
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_lastAddr  <= 8'h00;
            r_addrValid <= 1'b0;
        end else begin
            if (state == ADDR) begin
                r_lastAddr <= o_address;
            end
            if (i_invalidate) begin
                r_addrValid <= 1'b0;
            end else if (state == ADDR) begin
                r_addrValid <= 1'b1;
            end
        end
    end

    // Access-phase selects and write data load on entry to ACCESS and hold afterwards
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_readDataSelect  <= 1'b0;
            o_immediateSelect <= 1'b0;
            o_writeData       <= 8'h00;
            o_rspData         <= 8'h00;
        end else if (nextState == ACCESS) begin
            o_readDataSelect  <= accType[1];
            o_immediateSelect <= (accType == 2'b01);
            if (accType == 2'b11) begin
                o_writeData <= accData;
                o_rspData   <= 8'h00;
            end
        end else if (state == ACCESS && r_type != 2'b11) begin
            o_rspData <= i_readData;
        end
    end

    // Response strobe covers exactly the first IDLE cycle after ACCESS
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_rspValid <= 1'b0;
        end else begin
            o_rspValid <= (state == ACCESS);
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// tb/tb_mem_sequencer.sv - randomized self-checking bench for mem_sequencer
module tb_mem_sequencer;

    logic       clk = 1'b0;
    logic       nrst;
    logic       reqValid, reqValid0;
    logic [1:0] reqType;
    logic [7:0] reqAddr, reqWData;
    logic       inv;
    logic       reqReady, rspValid, addrEn, writeEn, rdSel, immSel, outEn;
    logic [7:0] rspData, address, writeData, readData;
    logic       reqReady0, rspValid0, addrEn0, writeEn0, rdSel0, immSel0, outEn0;
    logic [7:0] rspData0, address0, writeData0, readData0;

    int chkPass = 0;
    int chkTotal = 0;

    logic [7:0] ram [256];
    bit         ramWritten [256];
    logic [7:0] mram [256];
    logic [7:0] mLast;
    bit         mValid;

    always #5 clk = ~clk;

    mem_sequencer dut (
        .i_clk(clk), .i_nrst(nrst), .i_reqValid(reqValid), .o_reqReady(reqReady),
        .i_reqType(reqType), .i_reqAddr(reqAddr), .i_reqWData(reqWData), .i_invalidate(inv),
        .o_rspValid(rspValid), .o_rspData(rspData), .o_address(address), .o_addressEn(addrEn),
        .o_writeData(writeData), .o_writeEn(writeEn), .o_readDataSelect(rdSel),
        .o_immediateSelect(immSel), .o_outEnable(outEn), .i_readData(readData)
    );

    mem_sequencer #(.ADDR_REUSE(0)) dut0 (
        .i_clk(clk), .i_nrst(nrst), .i_reqValid(reqValid0), .o_reqReady(reqReady0),
        .i_reqType(reqType), .i_reqAddr(reqAddr), .i_reqWData(reqWData), .i_invalidate(inv),
        .o_rspValid(rspValid0), .o_rspData(rspData0), .o_address(address0), .o_addressEn(addrEn0),
        .o_writeData(writeData0), .o_writeEn(writeEn0), .o_readDataSelect(rdSel0),
        .o_immediateSelect(immSel0), .o_outEnable(outEn0), .i_readData(readData0)
    );

    function automatic logic [7:0] romVal(input logic [7:0] a, input logic imm);
        return imm ? (a ^ 8'h3C) : (a + 8'h51);
    endfunction

    function automatic logic [7:0] ramInit(input logic [7:0] a);
        return (a == 8'h10) ? 8'hA5 : (a * 8'd3 + 8'd7);
    endfunction

    // Memory behaviour: ROM halves and a data RAM that stores whatever the DUT writes
    always_comb begin
        readData = 8'h00;
        if (outEn) begin
            if (rdSel) readData = ramWritten[address] ? ram[address] : ramInit(address);
            else       readData = romVal(address, immSel);
        end
    end

    assign readData0 = outEn0 ? 8'hC3 : 8'h00;

    always @(negedge clk) begin
        if (writeEn) begin
            ram[address]        <= writeData;
            ramWritten[address] <= 1'b1;
        end
    end

    task automatic run_req(input logic [1:0] t, input logic [7:0] a, input logic [7:0] d, input bit invMid);
        bit         reuse, seen, both;
        int         expLat, lat, aen, acc;
        logic [7:0] expRsp, rsp, aenAddr, accWd, accRd;
        logic       accSel, accImm, accOe, accWe;
        reuse  = mValid && (a == mLast);
        expLat = reuse ? 2 : 3;
        expRsp = (t == 2'b11) ? 8'h00 : (t[1] ? mram[a] : romVal(a, t == 2'b01));
        if (t == 2'b11) mram[a] = d;
        if (!reuse) begin mLast = a; mValid = 1'b1; end
        if (invMid) mValid = 1'b0;

        @(negedge clk);
        reqType = t; reqAddr = a; reqWData = d; reqValid = 1'b1;
        for (int k = 0; k < 10 && !reqReady; k++) @(negedge clk);
        chkTotal++;
        if (reqReady !== 1'b1) $display("FAIL req_ready_wait got %b want 1", reqReady);
        else chkPass++;
        @(posedge clk);
        #1 reqValid = 1'b0;
        inv = invMid;
        seen = 0; both = 0; lat = 0; aen = 0; acc = 0; rsp = 8'hxx; aenAddr = 8'hxx;
        accWd = 8'hxx; accRd = 8'hxx; accSel = 1'bx; accImm = 1'bx; accOe = 1'bx; accWe = 1'bx;
        for (int k = 1; k <= 6 && !seen; k++) begin
            @(negedge clk);
            if (k == 2) inv = 1'b0;
            lat = k;
            if (addrEn) begin aen++; aenAddr = address; end
            if (writeEn && outEn) both = 1;
            if (writeEn || outEn) begin
                acc++; accSel = rdSel; accImm = immSel; accOe = outEn; accWe = writeEn;
                accWd = writeData; accRd = rspData;
            end
            if (rspValid) begin seen = 1; rsp = rspData; end
        end
        inv = 1'b0;

        chkTotal++;
        if (!seen || lat != expLat) $display("FAIL latency t=%0d a=%h got %0d (seen %0d) want %0d", t, a, lat, seen, expLat);
        else chkPass++;
        chkTotal++;
        if (aen != (reuse ? 0 : 1)) $display("FAIL addr_phase_count a=%h got %0d want %0d", a, aen, reuse ? 0 : 1);
        else chkPass++;
        if (!reuse) begin
            chkTotal++;
            if (aenAddr !== a) $display("FAIL addr_bus got %h want %h", aenAddr, a);
            else chkPass++;
        end
        chkTotal++;
        if (acc != 1) $display("FAIL access_cycles got %0d want 1", acc);
        else chkPass++;
        chkTotal++;
        if (both) $display("FAIL we_oe_overlap got 1 want 0");
        else chkPass++;
        chkTotal++;
        if (accSel !== t[1] || accImm !== (t == 2'b01)) $display("FAIL selects t=%0d got sel=%b imm=%b want sel=%b imm=%b", t, accSel, accImm, t[1], t == 2'b01);
        else chkPass++;
        chkTotal++;
        if (accWe !== (t == 2'b11) || accOe !== (t != 2'b11)) $display("FAIL strobes t=%0d got we=%b oe=%b", t, accWe, accOe);
        else chkPass++;
        if (t == 2'b11) begin
            chkTotal++;
            if (accWd !== d || accRd !== 8'h00) $display("FAIL write_access got wd=%h rsp=%h want wd=%h rsp=00", accWd, accRd, d);
            else chkPass++;
        end
        chkTotal++;
        if (rsp !== expRsp) $display("FAIL rsp_data t=%0d a=%h got %h want %h", t, a, rsp, expRsp);
        else chkPass++;
    endtask

    task automatic pulse_invalidate();
        @(negedge clk); inv = 1'b1;
        @(negedge clk); inv = 1'b0;
        mValid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        chkTotal++;
        if ({reqReady, rspValid, addrEn, writeEn, outEn, rdSel, immSel} !== 7'b1000000)
            $display("FAIL reset_ctrl got %b want 1000000", {reqReady, rspValid, addrEn, writeEn, outEn, rdSel, immSel});
        else chkPass++;
        chkTotal++;
        if ({rspData, address, writeData} !== 24'h0) $display("FAIL reset_data got %h want 000000", {rspData, address, writeData});
        else chkPass++;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_directed();
        run_req(2'b10, 8'h10, 8'h00, 0);
        run_req(2'b11, 8'h10, 8'h3C, 0);
        pulse_invalidate();
        run_req(2'b01, 8'h10, 8'h00, 0);
        run_req(2'b00, 8'h10, 8'h00, 0);
        run_req(2'b10, 8'h10, 8'h00, 0);
    endtask

    task automatic test_back_to_back();
        int rspAt [$];
        logic [7:0] rspVal [$];
        bit readyAtRsp;
        @(negedge clk);
        reqType = 2'b00; reqAddr = 8'h00; reqWData = 8'h00; reqValid = 1'b1;
        @(posedge clk);
        #1 reqAddr = 8'h01;
        readyAtRsp = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 4) reqValid = 1'b0;
            if (rspValid) begin
                rspAt.push_back(k); rspVal.push_back(rspData);
                if (k == 3 && reqReady) readyAtRsp = 1;
            end
        end
        mLast = 8'h01; mValid = 1'b1;
        chkTotal++;
        if (rspAt.size() != 2 || rspAt[0] != 3 || rspAt[1] != 6) $display("FAIL b2b_spacing got %0d responses want at 3 and 6", rspAt.size());
        else chkPass++;
        chkTotal++;
        if (!readyAtRsp) $display("FAIL b2b_ready_in_rsp got 0 want 1");
        else chkPass++;
        chkTotal++;
        if (rspVal.size() != 2 || rspVal[0] !== romVal(8'h00, 1'b0) || rspVal[1] !== romVal(8'h01, 1'b0))
            $display("FAIL b2b_data got %0d values want %h,%h", rspVal.size(), romVal(8'h00, 1'b0), romVal(8'h01, 1'b0));
        else chkPass++;
    endtask

    task automatic test_random();
        logic [1:0] t;
        logic [7:0] a, d;
        for (int i = 0; i < 40; i++) begin
            t = 2'($urandom_range(0, 3));
            a = 8'h10 + 8'($urandom_range(0, 3));
            d = 8'($urandom);
            if ($urandom_range(0, 9) == 0) pulse_invalidate();
            run_req(t, a, d, $urandom_range(0, 7) == 0);
        end
    endtask

    task automatic test_mid_reset();
        bit gotRsp;
        @(negedge clk);
        reqType = 2'b11; reqAddr = 8'h77; reqWData = 8'h99; reqValid = 1'b1;
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chkTotal++;
        if (writeEn !== 1'b1) $display("FAIL mid_reset_pre_we got %b want 1", writeEn);
        else chkPass++;
        mram[8'h77] = 8'h99;
        #2 nrst = 1'b0;
        #1;
        chkTotal++;
        if ({writeEn, outEn, addrEn, rspValid, reqReady} !== 5'b00001) $display("FAIL mid_reset_ctrl got %b want 00001", {writeEn, outEn, addrEn, rspValid, reqReady});
        else chkPass++;
        chkTotal++;
        if ({address, writeData, rspData} !== 24'h0) $display("FAIL mid_reset_data got %h want 000000", {address, writeData, rspData});
        else chkPass++;
        mValid = 1'b0; mLast = 8'h00;
        @(negedge clk);
        nrst = 1'b1;
        gotRsp = 0;
        repeat (4) begin @(negedge clk); if (rspValid) gotRsp = 1; end
        chkTotal++;
        if (gotRsp) $display("FAIL mid_reset_no_rsp got 1 want 0");
        else chkPass++;
        run_req(2'b11, 8'h77, 8'h42, 0);
    endtask

    task automatic test_no_reuse();
        int lat, aen;
        bit seen;
        logic [7:0] rsp;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reqType = 2'b10; reqAddr = 8'h20; reqWData = 8'h00; reqValid0 = 1'b1;
            for (int k = 0; k < 10 && !reqReady0; k++) @(negedge clk);
            @(posedge clk);
            #1 reqValid0 = 1'b0;
            seen = 0; lat = 0; aen = 0; rsp = 8'hxx;
            for (int k = 1; k <= 6 && !seen; k++) begin
                @(negedge clk);
                lat = k;
                if (addrEn0) aen++;
                if (rspValid0) begin seen = 1; rsp = rspData0; end
            end
            chkTotal++;
            if (!seen || lat != 3) $display("FAIL noreuse_latency got %0d want 3", lat);
            else chkPass++;
            chkTotal++;
            if (aen != 1) $display("FAIL noreuse_addr_phase got %0d want 1", aen);
            else chkPass++;
            chkTotal++;
            if (rsp !== 8'hC3) $display("FAIL noreuse_rsp got %h want c3", rsp);
            else chkPass++;
        end
    endtask

    initial begin
        nrst = 1'b0; reqValid = 1'b0; reqValid0 = 1'b0; inv = 1'b0;
        reqType = 2'b00; reqAddr = 8'h00; reqWData = 8'h00;
        mValid = 1'b0; mLast = 8'h00;
        for (int i = 0; i < 256; i++) mram[i] = ramInit(8'(i));
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        pulse_invalidate();
        run_req(2'b01, 8'h10, 8'h00, 0);
        test_mid_reset();
        test_no_reuse();
        $display("%0d/%0d checks passed", chkPass, chkTotal);
        $finish;
    end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 SHALL have parameter ADDR_REUSE, default 1, meaning 1 = skip the address phase when the request address matches the last latched address.
REQ-002 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port i_nrst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_reqValid  input  1  core request valid.
REQ-005 SHALL have port o_reqReady  output  1  sequencer accepts a request this cycle.
REQ-006 SHALL have port i_reqType  input  2  request type: 00 program fetch, 01 immediate fetch, 10 data read, 11 data write.
REQ-007 SHALL have port i_reqAddr  input  8  target address.
REQ-008 SHALL have port i_reqWData  input  8  write data, used for type 11 only.
REQ-009 SHALL have port i_invalidate  input  1  clears the address-reuse tracking.
REQ-010 SHALL have port o_rspValid  output  1  one-cycle response pulse.
REQ-011 SHALL have port o_rspData  output  8  read result; 0x00 for writes.
REQ-012 SHALL have port o_address  output  8  memory address bus.
REQ-013 SHALL have port o_addressEn  output  1  memory address latch enable.
REQ-014 SHALL have port o_writeData  output  8  memory write data.
REQ-015 SHALL have port o_writeEn  output  1  memory write enable, write happens in the clock-high phase.
REQ-016 SHALL have port o_readDataSelect  output  1  1 = data RAM, 0 = program ROM.
REQ-017 SHALL have port o_immediateSelect  output  1  1 = immediate ROM half, 0 = program ROM half.
REQ-018 SHALL have port o_outEnable  output  1  memory drives the read bus.
REQ-019 SHALL have port i_readData  input  8  memory read bus.

Function
REQ-020 SHALL implement the FSM states IDLE, ADDR and ACCESS.
REQ-021 SHALL assert o_reqReady only in IDLE, and a request SHALL be accepted on a rising edge where i_reqValid and o_reqReady are both 1.
REQ-022 SHALL register type, address and write data at acceptance and hold them stable until the next acceptance.
REQ-023 SHALL transition IDLE to ADDR on acceptance, or IDLE to ACCESS when ADDR_REUSE=1, r_addrValid=1 and i_reqAddr equals r_lastAddr.
REQ-024 SHALL, in ADDR, drive o_addressEn=1 and o_address=the registered address, and transition to ACCESS; on that edge r_lastAddr SHALL take the address and r_addrValid SHALL be set to 1.
REQ-025 SHALL, in ACCESS, drive o_readDataSelect=type[1] and o_immediateSelect=(type==01).
REQ-026 SHALL, in ACCESS for a read type, drive o_outEnable=1 and o_writeEn=0, and capture i_readData into o_rspData at the end of the cycle.
REQ-027 SHALL, in ACCESS for a write type, drive o_writeEn=1, o_outEnable=0, o_writeData=the registered data and o_rspData=0x00.
REQ-028 SHALL transition ACCESS to IDLE unconditionally and assert o_rspValid for exactly the first IDLE cycle.
REQ-029 SHALL give a latency from acceptance edge to o_rspValid of 3 cycles on the address-phase path and 2 cycles on the reuse path.
REQ-030 SHALL allow a request to be accepted in the same cycle that o_rspValid is high.
REQ-031 SHALL drive o_addressEn, o_writeEn and o_outEnable to 0 outside their own states, and never assert o_writeEn and o_outEnable together.
REQ-032 SHALL clear r_addrValid on the next edge when i_invalidate=1; i_invalidate SHALL take priority over a set by ADDR on the same edge.
REQ-033 SHALL treat type 00 and type 01 to the same 8-bit address as the same latched address, because the immediate bit is not latched.
REQ-034 SHALL hold o_address, o_writeData, o_readDataSelect and o_immediateSelect at their last values outside ACCESS.

Reset
REQ-035 SHALL, on i_nrst=0 at any time including mid-ADDR or mid-ACCESS, immediately force state=IDLE, r_addrValid=0, r_lastAddr=0x00, all enables 0, o_rspValid=0 and all data and address outputs 0x00.
REQ-036 SHALL not emit a response for a request interrupted by reset.

Verification
REQ-037 SHALL cover: data read at 0x10, memory returns 0xA5 -> addressEn in cycle 1, outEnable with readDataSelect=1 in cycle 2, rspValid with 0xA5 in cycle 3.
REQ-038 SHALL cover: write 0x3C to 0x10 immediately after REQ-037 -> no addressEn, writeEn with writeData=0x3C one cycle later, rspData=0x00.
REQ-039 SHALL cover: immediate fetch at 0x10 after i_invalidate pulse -> addressEn reasserted, immediateSelect=1, readDataSelect=0.
REQ-040 SHALL cover: back-to-back fetches at 0x00 and 0x01 with i_reqValid held high -> second accepted in the rspValid cycle of the first, 3-cycle spacing.
REQ-041 SHALL cover: i_nrst low during ACCESS of a write -> writeEn drops without a clock edge, no rspValid, and the next request to the same address takes the address phase.
REQ-042 SHALL cover: ADDR_REUSE=0 with repeated address 0x20 -> address phase on every request.
